// File: rtl/ultrasonic_range_pkg.sv
// Shared types and constants for the ultrasonic ranging controller.
package ultrasonic_range_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam int DIST_W      = 7;
  localparam int MAX_DIST_CM = 127;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ultrasonic_range_ctrl_echo_sync.sv
// Two-flop synchroniser for the raw echo input, plus a delayed copy for edge detection.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_echo,
  output logic o_echo_s,
  output logic o_echo_prev
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_echo;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_echo_s    = r_sync;
  assign o_echo_prev = r_prev;

endmodule

// File: rtl/ultrasonic_range_ctrl.sv
// Ultrasonic trigger/echo ranging controller producing a saturated 7-bit distance in cm.
// Optional build macro MEDIAN3_FILTER_EN: report the median of the last three raw results.
module ultrasonic_range_ctrl
  import ultrasonic_range_pkg::*;
#(
  parameter int TRIG_CYCLES    = 10,
  parameter int CYCLES_PER_CM  = 4,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int HOLDOFF_CYCLES = 500,
  parameter int MAX_DIST       = MAX_DIST_CM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] leading_distance,
  output logic              dist_valid,
  output logic              timeout_err
);

  localparam int CNT_W = max3(cnt_w(TRIG_CYCLES), cnt_w(TIMEOUT_CYCLES), cnt_w(HOLDOFF_CYCLES));
  localparam int SUB_W = cnt_w(CYCLES_PER_CM);

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TOUT_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_DIST);

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v == CM_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [DIST_W-1:0] med3(input logic [DIST_W-1:0] a,
                                              input logic [DIST_W-1:0] b,
                                              input logic [DIST_W-1:0] c);
    logic [DIST_W-1:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [SUB_W-1:0]  r_sub;
  logic [DIST_W-1:0] r_cm;
  logic [DIST_W-1:0] r_dist;
  logic              r_dist_valid;
  logic              r_timeout_err;

  logic              w_echo_s;
  logic              w_echo_prev;
  logic              w_rise;
  logic              w_done;
  logic              w_tout;
  logic              w_trig;
  logic [SUB_W-1:0]  w_sub_base;
  logic [SUB_W-1:0]  w_sub_inc;
  logic [DIST_W-1:0] w_cm_base;
  logic [DIST_W-1:0] w_cm_inc;
  logic [DIST_W-1:0] w_raw;
  logic [DIST_W-1:0] w_result;

  echo_sync u_echo_sync (
    .clk         (clk),
    .rst         (rst),
    .i_echo      (echo),
    .o_echo_s    (w_echo_s),
    .o_echo_prev (w_echo_prev)
  );

  assign w_rise = w_echo_s & ~w_echo_prev;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // In MEASURE the fall is checked before the high-time limit, so a coincident fall is a normal result
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    case (r_state)
      IDLE:      if (enable) w_state_nxt = TRIG;
      TRIG:      if (r_cnt == TRIG_LAST) w_state_nxt = WAIT_ECHO;
      WAIT_ECHO: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
        end else if (r_cnt == TOUT_LAST) begin
          w_state_nxt = HOLDOFF;
          w_done      = 1'b1;
          w_tout      = 1'b1;
        end
      end
      MEASURE: begin
        if (!w_echo_s) begin
          w_state_nxt = HOLDOFF;
          w_done      = 1'b1;
        end else if (r_cnt >= TOUT_LIM) begin
          w_state_nxt = HOLDOFF;
          w_done      = 1'b1;
          w_tout      = 1'b1;
        end
      end
      HOLDOFF:   if (r_cnt == HOLD_LAST) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_trig = (r_state == TRIG);
  end

  // The rise cycle starts from a cleared count and is itself echo cycle 1
  always_comb begin
    w_sub_base = (r_state == MEASURE) ? r_sub : '0;
    w_cm_base  = (r_state == MEASURE) ? r_cm  : '0;
    if (w_sub_base == SUB_LAST) begin
      w_sub_inc = '0;
      w_cm_inc  = sat_inc(w_cm_base);
    end else begin
      w_sub_inc = w_sub_base + 1'b1;
      w_cm_inc  = w_cm_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sub <= '0;
      r_cm  <= '0;
    end else begin
      case (r_state)
        IDLE: r_cnt <= '0;
        WAIT_ECHO: begin
          if (w_rise) begin
            r_cnt <= CNT_W'(1);
            r_sub <= w_sub_inc;
            r_cm  <= w_cm_inc;
          end else begin
            r_cnt <= (w_state_nxt == r_state) ? r_cnt + 1'b1 : '0;
          end
        end
        MEASURE: begin
          if (w_state_nxt == MEASURE) begin
            r_cnt <= r_cnt + 1'b1;
            r_sub <= w_sub_inc;
            r_cm  <= w_cm_inc;
          end else begin
            r_cnt <= '0;
          end
        end
        default: r_cnt <= (w_state_nxt == r_state) ? r_cnt + 1'b1 : '0;
      endcase
    end
  end

  assign w_raw = w_tout ? CM_MAX : r_cm;

`ifdef MEDIAN3_FILTER_EN
  logic [DIST_W-1:0] r_h0;
  logic [DIST_W-1:0] r_h1;

  assign w_result = med3(w_raw, r_h0, r_h1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h0 <= '0;
      r_h1 <= '0;
    end else if (w_done) begin
      r_h0 <= w_raw;
      r_h1 <= r_h0;
    end
  end
`else
  assign w_result = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dist        <= '0;
      r_dist_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dist_valid  <= w_done;
      r_timeout_err <= w_tout;
      if (w_done) r_dist <= w_result;
    end
  end

  assign trig             = w_trig;
  assign leading_distance = r_dist;
  assign dist_valid       = r_dist_valid;
  assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_ultrasonic_range_ctrl.sv
// Directed bench for ultrasonic_range_ctrl: table of echo scenarios plus a mid-measurement reset sequence.
module tb_ultrasonic_range_ctrl;

  localparam int TRIG_CYCLES    = 10;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HOLDOFF_CYCLES = 500;

  // kind: 0 = echo pulse of 'width' cycles after 'delay', 1 = no echo, 2 = echo stuck high from before trig
  typedef struct {
    int         kind;
    int         delay;
    int         width;
    logic [6:0] raw;
    logic       err;
    int         lat;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       echo;
  logic       trig;
  logic [6:0] leading_distance;
  logic       dist_valid;
  logic       timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] h0, h1;

  ultrasonic_range_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .echo             (echo),
    .trig             (trig),
    .leading_distance (leading_distance),
    .dist_valid       (dist_valid),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] median(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    logic [6:0] t;
    if (a > b) begin t = a; a = b; b = t; end
    if (b > c) begin t = b; b = c; c = t; end
    if (a > b) begin t = a; a = b; b = t; end
    return b;
  endfunction

  task automatic model_step(input logic [6:0] raw, output logic [6:0] out);
`ifdef MEDIAN3_FILTER_EN
    out = median(raw, h0, h1);
`else
    out = raw;
`endif
    h1 = h0;
    h0 = raw;
  endtask

  task automatic wait_trig(output int n);
    n = 0;
    while (!trig && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!trig) chk("trig_wait_expired", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int         cnt;
    int         got_t;
    logic       seen;
    logic [6:0] got_d;
    logic       got_e;
    logic [6:0] exp_d;
    cnt = 0;
    while (trig && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk({name, "_trig_len"}, cnt, TRIG_CYCLES);
    seen  = 1'b0;
    got_t = -1;
    got_d = '0;
    got_e = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      if (t > 0) @(negedge clk);
      if (dist_valid) begin
        seen  = 1'b1;
        got_t = t;
        got_d = leading_distance;
        got_e = timeout_err;
        break;
      end
      case (v.kind)
        0:       echo = (t >= v.delay) && (t < v.delay + v.width);
        1:       echo = 1'b0;
        default: echo = 1'b1;
      endcase
    end
    echo = 1'b0;
    model_step(v.raw, exp_d);
    chk({name, "_valid_seen"}, int'(seen), 1);
    chk({name, "_latency"}, got_t, v.lat);
    chk({name, "_dist"}, int'(got_d), int'(exp_d));
    chk({name, "_err"}, int'(got_e), int'(v.err));
    @(negedge clk);
    chk({name, "_valid_pulse"}, int'(dist_valid), 0);
    chk({name, "_err_pulse"}, int'(timeout_err), 0);
    chk({name, "_held"}, int'(leading_distance), int'(exp_d));
  endtask

  vec_t tab1 [6];
  vec_t tab2 [3];

  initial begin
    int n;
    int bad;

    tab1[0] = '{0, 20, 40,   7'd10,  1'b0, 63};
    tab1[1] = '{0, 20, 43,   7'd10,  1'b0, 66};
    tab1[2] = '{0, 20, 600,  7'd127, 1'b0, 623};
    tab1[3] = '{1, 0,  0,    7'd127, 1'b1, TIMEOUT_CYCLES};
    tab1[4] = '{0, 20, 2100, 7'd127, 1'b1, 20 + TIMEOUT_CYCLES + 3};
    tab1[5] = '{2, 0,  0,    7'd127, 1'b1, TIMEOUT_CYCLES};
    tab2[0] = '{0, 20, 40,   7'd10,  1'b0, 63};
    tab2[1] = '{0, 20, 200,  7'd50,  1'b0, 223};
    tab2[2] = '{0, 20, 80,   7'd20,  1'b0, 103};

    h0     = '0;
    h1     = '0;
    rst    = 1'b1;
    enable = 1'b1;
    echo   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", int'(trig), 0);
    chk("rst_dist", int'(leading_distance), 0);
    chk("rst_valid", int'(dist_valid), 0);
    chk("rst_err", int'(timeout_err), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (tab1[i].kind == 2) echo = 1'b1;
      wait_trig(n);
      if (i > 0) chk($sformatf("v%0d_holdoff_gap", i), n, HOLDOFF_CYCLES);
      run_vec(tab1[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of MEASURE: measurement discarded, later fall ignored
    wait_trig(n);
    chk("rstseq_holdoff_gap", n, HOLDOFF_CYCLES);
    n = 0;
    while (trig && n < 100) begin
      n++;
      @(negedge clk);
    end
    for (int t = 0; t < 40; t++) begin
      echo = (t >= 20);
      @(negedge clk);
    end
    enable = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("midrst_trig", int'(trig), 0);
    chk("midrst_dist", int'(leading_distance), 0);
    chk("midrst_valid", int'(dist_valid), 0);
    rst  = 1'b0;
    echo = 1'b0;
    h0   = '0;
    h1   = '0;
    bad  = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (dist_valid || trig) bad++;
    end
    chk("midrst_no_activity", bad, 0);
    chk("midrst_dist_hold", int'(leading_distance), 0);
    enable = 1'b1;

    for (int i = 0; i < 3; i++) begin
      wait_trig(n);
      if (i > 0) chk($sformatf("m%0d_holdoff_gap", i), n, HOLDOFF_CYCLES);
      run_vec(tab2[i], $sformatf("m%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
